// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, one bit per clock, LSB first
// Optional signed overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             d_bit, br_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor stage on the current LSBs.
    assign d_bit  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    assign br_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: the operand LSBs are now the original MSBs.
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = br_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    ovf_d    = (a_sh_q[0] != b_sh_q[0]) && (d_bit != a_sh_q[0]);
`endif
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured on the edge that accepts start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured on the edge that accepts start.
REQ-007 SHALL have port diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-008 SHALL have port borrow_out  output  1  final borrow; 1 when unsigned a < unsigned b.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking diff/borrow_out valid.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at a rising edge, SHALL capture a and b into operand shift registers, clear the borrow flip-flop, clear the bit counter, and enter SHIFT.
REQ-013 In IDLE with start=0, SHALL remain in IDLE and hold diff and borrow_out unchanged.
REQ-014 Each SHIFT cycle SHALL process the LSBs a0, b0 with borrow br as a full-subtractor stage: d = a0^b0^br and br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-015 Each SHIFT cycle SHALL shift d into the result register MSB, shift both operand registers right by one, and increment the counter.
REQ-016 SHALL remain in SHIFT for exactly WIDTH cycles, then enter DONE.
REQ-017 On entering DONE, diff SHALL equal the completed result and borrow_out SHALL equal the final borrow.
REQ-018 done SHALL be 1 for exactly one cycle while in DONE, after which the FSM returns to IDLE unconditionally.
REQ-019 Latency: done SHALL be high in the cycle following the (WIDTH+1)th rising edge after the edge that accepted start.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-021 start held high continuously SHALL start a new operation on the edge after DONE returns to IDLE, giving back-to-back operations every WIDTH+2 cycles.
REQ-022 diff and borrow_out SHALL hold their last completed values from DONE until the next DONE.
REQ-023 Changes on a and b after capture SHALL NOT affect the result.

Reset
REQ-024 rst_n=0 SHALL, asynchronously and at any state (including mid-SHIFT), force the FSM to IDLE.
REQ-025 rst_n=0 SHALL clear the counter, operand registers, and borrow flip-flop.
REQ-026 rst_n=0 SHALL force diff=0, borrow_out=0, busy=0, and done=0.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Configuration
REQ-028 When the macro SERIAL_SUB_SIGNED_OVF_EN is defined, the block SHALL add output port ovf (1 bit) giving two's-complement overflow: (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
REQ-029 ovf SHALL update and hold with the same timing as borrow_out and SHALL reset to 0.
REQ-030 When SERIAL_SUB_SIGNED_OVF_EN is undefined, port ovf and its logic SHALL be absent, with all other behaviour unchanged.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, start pulse -> done after 9 edges with diff=0x02, borrow_out=0, and busy high for 9 cycles.
REQ-032 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0xFF -> diff=0x01, borrow_out=1; a=b=0x00 -> diff=0x00, borrow_out=0.
REQ-033 start re-pulsed with a=0x10, b=0x01 during SHIFT of a 0x05-0x03 operation -> single done, diff=0x02; done count=1.
REQ-034 rst_n pulsed low at the 4th SHIFT cycle -> immediate busy=0, diff=0, no done; next start with a=0x09, b=0x04 -> diff=0x05.
REQ-035 With SERIAL_SUB_SIGNED_OVF_EN defined: a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow_out=0; a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow_out=1.
REQ-036 start held high for 40 cycles -> done pulses at a period of exactly 10 cycles, with each result correct.
